// File: rtl/nic_pkg.sv
// nic_pkg: NIC FSM state encoding and preamble/SFD nibbles shared by the TX serializer and the RX stripper.
package nic_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_IFG} state_t;
    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB      = 4'hD;
endpackage

// File: rtl/nibble_serializer.sv
// nibble_serializer: MAC byte stream to PHY nibbles (low first) with preamble, SFD and inter-frame gap.
module nibble_serializer
    import nic_pkg::*;
#(
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [3:0] tx_data,
    output logic       tx_en,
    output logic       tx_underrun,
    output logic       busy
);
    localparam int CNT_MAX = (PRE_NIBBLES + 1 > IFG_NIBBLES) ? PRE_NIBBLES + 1 : IFG_NIBBLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PRE_END = CW'(PRE_NIBBLES);
    localparam logic [CW-1:0] IFG_END = CW'(IFG_NIBBLES > 0 ? IFG_NIBBLES - 1 : 0);
    localparam state_t GAP_ST = IFG_NIBBLES > 0 ? ST_IFG : ST_IDLE;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    byte_q, byte_n;
    logic          last_q, last_n, sel, sel_n, underrun_n;
    logic [3:0]    data_n;

    assign din_ready = state == ST_IDLE || (state == ST_DATA && sel && !last_q);
    assign busy      = state != ST_IDLE;

    // Outputs are registered from the next-state view so the nibble appears the cycle it belongs to.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sel_n      = sel;
        byte_n     = byte_q;
        last_n     = last_q;
        underrun_n = 1'b0;
        case (state)
            ST_IDLE: if (din_valid) begin
                byte_n  = din;
                last_n  = din_last;
                cnt_n   = '0;
                state_n = ST_PRE;
            end
            ST_PRE: if (cnt == PRE_END) begin
                sel_n   = 1'b0;
                state_n = ST_DATA;
            end else cnt_n = cnt + 1'b1;
            ST_DATA: begin
                sel_n = !sel;
                if (sel && (last_q || !din_valid)) begin
                    state_n    = GAP_ST;
                    cnt_n      = '0;
                    underrun_n = !last_q;
                end else if (sel) begin
                    byte_n = din;
                    last_n = din_last;
                end
            end
            default: if (cnt == IFG_END) state_n = ST_IDLE;
                     else cnt_n = cnt + 1'b1;
        endcase
        data_n = state_n == ST_PRE  ? (cnt_n < PRE_END ? PREAMBLE_NIB : SFD_NIB) :
                 state_n == ST_DATA ? (sel_n ? byte_n[7:4] : byte_n[3:0]) : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            byte_q      <= '0;
            last_q      <= 1'b0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            byte_q      <= byte_n;
            last_q      <= last_n;
            tx_data     <= data_n;
            tx_en       <= state_n == ST_PRE || state_n == ST_DATA;
            tx_underrun <= underrun_n;
        end
    end
endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: checks the serializer against a per-cycle timeline built from frame contents.
module tb_nibble_serializer;
    import nic_pkg::*;
    localparam int PRE = 15;
    localparam int IFG = 24;

    logic       clock = 1'b0, reset = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0, din_last = 1'b0;
    logic       din_ready, tx_en, tx_underrun, busy;
    logic [3:0] tx_data;
    int         errors = 0, checks = 0;

    typedef struct packed {logic en; logic busy; logic [3:0] d;} exp_t;
    typedef logic [7:0] byte_q_t[$];
    typedef logic       bit_q_t[$];
    typedef exp_t       exp_q_t[$];

    nibble_serializer #(.PRE_NIBBLES(PRE), .IFG_NIBBLES(IFG)) dut (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(din_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clock = ~clock;

    // One entry per cycle after the first accept: nibbles, then the gap, then one idle/accept cycle.
    function automatic exp_q_t model(input byte_q_t b, input bit_q_t l);
        exp_q_t q;
        for (int i = 0; i < b.size(); i++) begin
            if (i == 0 || l[i-1]) begin
                for (int p = 0; p < PRE; p++) q.push_back('{1'b1, 1'b1, PREAMBLE_NIB});
                q.push_back('{1'b1, 1'b1, SFD_NIB});
            end
            q.push_back('{1'b1, 1'b1, b[i][3:0]});
            q.push_back('{1'b1, 1'b1, b[i][7:4]});
            if (l[i]) begin
                for (int g = 0; g < IFG; g++) q.push_back('{1'b0, 1'b1, 4'h0});
                q.push_back('{1'b0, 1'b0, 4'h0});
            end
        end
        return q;
    endfunction

    task automatic send_frames(input byte_q_t b, input bit_q_t l, input bit toggle, input string name);
        exp_q_t e;
        int     idx;
        bit     acc;
        e = model(b, l);
        idx = 0;
        @(negedge clock);
        checks++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: din_ready=%b busy=%b, expected 1 0", name, din_ready, busy);
        end
        din = b[0]; din_last = l[0]; din_valid = 1'b1; acc = 1'b1;
        foreach (e[k]) begin
            @(negedge clock);
            if (acc) idx++;
            checks++;
            if (tx_en !== e[k].en || tx_data !== e[k].d || busy !== e[k].busy || tx_underrun !== 1'b0 ||
                (!e[k].en && din_ready !== !e[k].busy)) begin
                errors++;
                $display("FAIL %s cycle %0d: tx_en=%b tx_data=%h busy=%b underrun=%b din_ready=%b, expected %b %h %b 0 (ready=%b when idle-side)",
                         name, k + 1, tx_en, tx_data, busy, tx_underrun, din_ready, e[k].en, e[k].d, e[k].busy, !e[k].busy);
            end
            if (idx < b.size() && (din_ready || !toggle)) begin
                din = b[idx]; din_last = l[idx]; din_valid = 1'b1;
            end else if (toggle && !din_ready) begin
                din_valid = 1'($urandom); din = 8'($urandom); din_last = 1'($urandom);
            end else din_valid = 1'b0;
            acc = din_valid && din_ready;
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; din_valid = 1'b1; din = 8'hFF; din_last = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (tx_en !== 1'b0 || tx_data !== 4'h0 || tx_underrun !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: tx_en=%b tx_data=%h underrun=%b busy=%b din_ready=%b, expected 0 0 0 0 1",
                     tx_en, tx_data, tx_underrun, busy, din_ready);
        end
        reset = 1'b0; din_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b tx_en=%b, expected 0 0", busy, tx_en);
        end
    endtask

    task automatic test_frame();
        byte_q_t b = {8'hA1, 8'h2B, 8'h3C};
        bit_q_t  l = {1'b0, 1'b0, 1'b1};
        send_frames(b, l, 1'b0, "frame3");
    endtask

    task automatic test_single_byte();
        byte_q_t b = {8'h7E};
        bit_q_t  l = {1'b1};
        send_frames(b, l, 1'b0, "single");
    endtask

    task automatic test_underrun();
        logic [3:0] ed;
        byte_q_t    b = {8'hC9};
        bit_q_t     l = {1'b1};
        @(negedge clock);
        din = 8'h11; din_last = 1'b0; din_valid = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clock);
            din_valid = 1'b0;
            ed = k <= PRE ? 4'h5 : k == PRE + 1 ? 4'hD : k <= PRE + 3 ? 4'h1 : 4'h0;
            checks++;
            if (tx_en !== (k <= 18) || tx_data !== ed || tx_underrun !== (k == 19) || busy !== (k <= 42) ||
                (k > 18 && din_ready !== (k == 43))) begin
                errors++;
                $display("FAIL underrun cycle %0d: tx_en=%b tx_data=%h underrun=%b busy=%b din_ready=%b, expected %b %h %b %b",
                         k, tx_en, tx_data, tx_underrun, busy, din_ready, k <= 18, ed, k == 19, k <= 42);
            end
        end
        send_frames(b, l, 1'b0, "after_underrun");
    endtask

    task automatic test_back_to_back();
        byte_q_t b = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4};
        bit_q_t  l = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        send_frames(b, l, 1'b0, "back_to_back");
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] ed;
        byte_q_t    b = {8'h55};
        bit_q_t     l = {1'b1};
        @(negedge clock);
        din = 8'h12; din_last = 1'b0; din_valid = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            din = 8'h34; din_last = 1'b1;
            if (k >= 17) begin
                ed = k == 17 ? 4'h2 : k == 18 ? 4'h1 : 4'h4;
                checks++;
                if (tx_en !== 1'b1 || tx_data !== ed) begin
                    errors++;
                    $display("FAIL mid_frame nibble %0d: tx_en=%b tx_data=%h, expected 1 %h", k, tx_en, tx_data, ed);
                end
            end
        end
        reset = 1'b1; din_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (tx_en !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || tx_data !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: tx_en=%b busy=%b din_ready=%b tx_data=%h, expected 0 0 1 0", tx_en, busy, din_ready, tx_data);
        end
        reset = 1'b0;
        send_frames(b, l, 1'b0, "after_reset");
    endtask

    task automatic test_valid_toggle();
        byte_q_t b = {8'h5A, 8'hC3, 8'h0F, 8'h96};
        bit_q_t  l = {1'b0, 1'b0, 1'b1, 1'b1};
        send_frames(b, l, 1'b1, "valid_toggle");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            byte_q_t b;
            bit_q_t  l;
            int      nf, len;
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) begin
                    b.push_back(8'($urandom));
                    l.push_back(i == len - 1);
                end
            end
            send_frames(b, l, 1'($urandom), $sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_single_byte();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_valid_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
